// File: rtl/rx_block_aligner_130b.sv
// rx_block_aligner_130b
//   Receive-side 128b/130b block aligner and deserializer. It takes one serial
//   bit per accepted cycle. It hunts for the 2-bit sync header and declares
//   lock after LOCK_CNT consecutive valid headers. While locked, it splits each
//   128-bit payload into 16 bytes and tags the block as data or ordered set.
//
// Ports
//   clk_8G     in   bit clock, all logic on posedge
//   rst_8G     in   asynchronous active-low reset
//   rx_data    in   serial bit, sampled only when rx_valid=1
//   rx_valid   in   rx_data carries a bit this cycle (gaps hold all state)
//   byte_out   out  deserialized payload byte (holds when byte_valid=0)
//   byte_valid out  one-cycle strobe for byte_out
//   blk_start  out  with byte_valid, marks byte 0 of a block
//   k_out      out  1 = ordered set (hdr 1,0), 0 = data (hdr 0,1)
//   locked     out  block lock status
//   hdr_err    out  one-cycle pulse for an invalid header seen while locked
module rx_block_aligner_130b #(
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned ERR_MAX  = 4
) (
  input  logic       clk_8G,
  input  logic       rst_8G,
  input  logic       rx_data,
  input  logic       rx_valid,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic       blk_start,
  output logic       k_out,
  output logic       locked,
  output logic       hdr_err
);

  localparam logic [3:0] LOCK_N = 4'(LOCK_CNT);
  localparam logic [3:0] ERR_N  = 4'(ERR_MAX);

  typedef enum logic [1:0] {HUNT, CHECK, LOCKED} state_t;

  state_t     state_q, state_d;
  logic [7:0] bit_cnt_q, bit_cnt_d;
  logic [3:0] good_cnt_q, good_cnt_d;
  logic [3:0] bad_cnt_q, bad_cnt_d;
  logic       prev_bit_q, prev_bit_d;
  logic       prev_vld_q, prev_vld_d;
  logic       h0_q, h0_d;
  logic [7:0] sh_q, sh_d;
  logic [7:0] byte_out_q, byte_out_d;
  logic       byte_valid_q, byte_valid_d;
  logic       blk_start_q, blk_start_d;
  logic       k_q, k_d;
  logic       locked_q, locked_d;
  logic       hdr_err_q, hdr_err_d;
  logic       hdr_ok;

  always_ff @(posedge clk_8G or negedge rst_8G) begin
    if (!rst_8G) begin
      state_q      <= HUNT;
      bit_cnt_q    <= '0;
      good_cnt_q   <= '0;
      bad_cnt_q    <= '0;
      prev_bit_q   <= 1'b0;
      prev_vld_q   <= 1'b0;
      h0_q         <= 1'b0;
      sh_q         <= '0;
      byte_out_q   <= '0;
      byte_valid_q <= 1'b0;
      blk_start_q  <= 1'b0;
      k_q          <= 1'b0;
      locked_q     <= 1'b0;
      hdr_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      good_cnt_q   <= good_cnt_d;
      bad_cnt_q    <= bad_cnt_d;
      prev_bit_q   <= prev_bit_d;
      prev_vld_q   <= prev_vld_d;
      h0_q         <= h0_d;
      sh_q         <= sh_d;
      byte_out_q   <= byte_out_d;
      byte_valid_q <= byte_valid_d;
      blk_start_q  <= blk_start_d;
      k_q          <= k_d;
      locked_q     <= locked_d;
      hdr_err_q    <= hdr_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    good_cnt_d   = good_cnt_q;
    bad_cnt_d    = bad_cnt_q;
    prev_bit_d   = prev_bit_q;
    prev_vld_d   = prev_vld_q;
    h0_d         = h0_q;
    sh_d         = sh_q;
    byte_out_d   = byte_out_q;
    byte_valid_d = 1'b0;
    blk_start_d  = 1'b0;
    k_d          = k_q;
    locked_d     = locked_q;
    hdr_err_d    = 1'b0;
    hdr_ok       = 1'b0;

    if (rx_valid) begin
      // New bit enters at the MSB, so the first bit of a byte ends up at bit 0.
      sh_d = {rx_data, sh_q[7:1]};
      unique case (state_q)
        HUNT: begin
          prev_bit_d = rx_data;
          prev_vld_d = 1'b1;
          // A transition is taken as header (prev_bit, rx_data); the found
          // header already counts as the first good one.
          if (prev_vld_q && (rx_data != prev_bit_q)) begin
            bit_cnt_d  = 8'd2;
            good_cnt_d = 4'd1;
            if (LOCK_N == 4'd1) begin
              state_d   = LOCKED;
              locked_d  = 1'b1;
              k_d       = prev_bit_q;
              bad_cnt_d = '0;
            end else begin
              state_d = CHECK;
            end
          end
        end
        CHECK, LOCKED: begin
          bit_cnt_d = (bit_cnt_q == 8'd129) ? 8'd0 : bit_cnt_q + 8'd1;
          if (bit_cnt_q == 8'd0) h0_d = rx_data;
          if (bit_cnt_q == 8'd1) begin
            hdr_ok = (h0_q != rx_data);
            if (state_q == CHECK) begin
              if (hdr_ok) begin
                good_cnt_d = good_cnt_q + 4'd1;
                if (good_cnt_q + 4'd1 == LOCK_N) begin
                  state_d   = LOCKED;
                  locked_d  = 1'b1;
                  k_d       = h0_q;
                  bad_cnt_d = '0;
                end
              end else begin
                good_cnt_d = '0;
                state_d    = HUNT;
                prev_vld_d = 1'b0;
              end
            end else begin
              k_d = h0_q;
              if (hdr_ok) begin
                bad_cnt_d = '0;
              end else begin
                hdr_err_d = 1'b1;
                bad_cnt_d = bad_cnt_q + 4'd1;
                if (bad_cnt_q + 4'd1 == ERR_N) begin
                  state_d    = HUNT;
                  locked_d   = 1'b0;
                  good_cnt_d = '0;
                  prev_vld_d = 1'b0;
                end
              end
            end
          end
          // Byte n completes at bit 9+8n: bit_cnt >= 9 with low bits == 3'b001.
          if ((state_q == LOCKED) && (bit_cnt_q >= 8'd9) && (bit_cnt_q[2:0] == 3'd1)) begin
            byte_valid_d = 1'b1;
            byte_out_d   = {rx_data, sh_q[7:1]};
            blk_start_d  = (bit_cnt_q == 8'd9);
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  assign byte_out   = byte_out_q;
  assign byte_valid = byte_valid_q;
  assign blk_start  = blk_start_q;
  assign k_out      = k_q;
  assign locked     = locked_q;
  assign hdr_err    = hdr_err_q;

endmodule
